icache_controller: RTL and testbench



---
 rtl/icache_controller.sv | 101 ++++++++++
 tb/tb_icache_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache: 8 blocks of 16 bytes with a 3-bit tag.
// Hits return the word combinationally. A miss stalls the CPU and fills one block from memory.
module icache_controller #(
  parameter int NUM_BLOCKS = 8,
  parameter int MISS_CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic [9:0]            cpu_address,
  output logic [31:0]           cpu_instruction,
  output logic                  cpu_busywait,
  output logic                  mem_read,
  output logic [5:0]            mem_address,
  input  logic [127:0]          mem_readdata,
  input  logic                  mem_busywait,
  output logic [MISS_CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t state, state_next;

  logic [2:0]            tag, index;
  logic [1:0]            word;
  logic                  unused_byte_offset;
  logic [NUM_BLOCKS-1:0] valid;
  logic [2:0]            tag_store  [NUM_BLOCKS];
  logic [127:0]          data_store [NUM_BLOCKS];
  logic [127:0]          blk;
  logic [2:0]            miss_tag, miss_index;
  logic                  first_cycle_p0;
  logic                  hit, start_miss;

  function automatic logic [MISS_CNT_W-1:0] sat_inc(input logic [MISS_CNT_W-1:0] v);
    return (&v) ? v : v + MISS_CNT_W'(1);
  endfunction

  assign tag                = cpu_address[9:7];
  assign index              = cpu_address[6:4];
  assign word               = cpu_address[3:2];
  assign unused_byte_offset = ^cpu_address[1:0];

  assign blk             = data_store[index];
  assign hit             = cpu_read & valid[index] & (tag_store[index] == tag);
  assign cpu_instruction = hit ? blk[{word, 5'b0} +: 32] : 32'h0;
  assign start_miss      = (state == IDLE) & cpu_read & ~hit;

  always_comb begin
    state_next   = state;
    cpu_busywait = 1'b0;
    mem_read     = 1'b0;
    mem_address  = '0;
    case (state)
      IDLE: begin
        cpu_busywait = start_miss;
        if (start_miss) state_next = MEM_READ;
      end
      MEM_READ: begin
        mem_read     = 1'b1;
        mem_address  = {miss_tag, miss_index};
        cpu_busywait = 1'b1;
        // Memory only raises busywait after it has seen mem_read, so a low busywait in the
        // first cycle is stale.
        if (!first_cycle_p0 && !mem_busywait) state_next = UPDATE;
      end
      UPDATE: begin
        cpu_busywait = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      valid          <= '0;
      miss_count     <= '0;
      first_cycle_p0 <= 1'b0;
    end else begin
      state          <= state_next;
      first_cycle_p0 <= start_miss;
      if (start_miss) miss_count <= sat_inc(miss_count);
      if (state == UPDATE) valid[miss_index] <= 1'b1;
    end
  end

  // Miss address capture and block fill.
  always_ff @(posedge clock) begin
    if (start_miss) begin
      miss_tag   <= tag;
      miss_index <= index;
    end
    if (state == UPDATE && !reset) begin
      data_store[miss_index] <= mem_readdata;
      tag_store[miss_index]  <= miss_tag;
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
// Self-checking bench for icache_controller: a latency-randomised memory responder, a
// cache-content reference model checked every cycle, and directed checks with fixed values.
module tb_icache_controller;

  localparam int CW = 6;  // narrow counter so saturation is reachable in a short run

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_read;
  logic [9:0]    cpu_address;
  logic [31:0]   cpu_instruction;
  logic          cpu_busywait;
  logic          mem_read;
  logic [5:0]    mem_address;
  logic [127:0]  mem_readdata;
  logic          mem_busywait;
  logic [CW-1:0] miss_count;

  int n_vec = 0;
  int n_mis = 0;
  bit started = 1'b0;

  icache_controller #(.NUM_BLOCKS(8), .MISS_CNT_W(CW)) dut (
    .clock           (clock),
    .reset           (reset),
    .cpu_read        (cpu_read),
    .cpu_address     (cpu_address),
    .cpu_instruction (cpu_instruction),
    .cpu_busywait    (cpu_busywait),
    .mem_read        (mem_read),
    .mem_address     (mem_address),
    .mem_readdata    (mem_readdata),
    .mem_busywait    (mem_busywait),
    .miss_count      (miss_count)
  );

  always #5 clock = ~clock;

  // Instruction memory contents: blocks 0 and 1 hold fixed words, the rest are address-derived.
  function automatic logic [127:0] mem_block(input logic [5:0] a);
    logic [127:0] b;
    for (int w = 0; w < 4; w++)
      b[32*w +: 32] = {8'(a), 8'(w), 16'(int'(a) * 4951 + w * 3855 + 1)};
    if (a == 6'd0) b = {32'h03010103, 32'h00030001, 32'h0002000C, 32'h0001000F};
    if (a == 6'd1) b[31:0] = 32'h07010102;
    return b;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Memory responder: busy for 1..4 cycles after noticing mem_read, then returns the block.
  int mem_cnt = 0;
  always begin
    @(posedge clock);
    #1;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_busywait = 1'b0;
        mem_readdata = mem_block(mem_address);
      end
    end else if (mem_read) begin
      mem_busywait = 1'b1;
      mem_cnt      = $urandom_range(1, 4);
    end
  end

  // Reference model: cache contents plus the stall phase of the current miss.
  bit             m_valid [8];
  logic [2:0]     m_tag   [8];
  logic [127:0]   m_data  [8];
  logic [CW-1:0]  m_cnt = '0;
  logic [5:0]     m_miss = '0;
  int             m_phase = 0;  // 0 serving, 1 waiting on memory, 2 filling
  int             m_age = 0;

  function automatic bit model_hit();
    return cpu_read && m_valid[cpu_address[6:4]] && (m_tag[cpu_address[6:4]] == cpu_address[9:7]);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_phase = 0;
      m_cnt   = '0;
    end else begin
      case (m_phase)
        0: if (cpu_read && !model_hit()) begin
          m_miss  = cpu_address[9:4];
          m_phase = 1;
          m_age   = 0;
          if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end
        1: begin
          if (m_age > 0 && !mem_busywait) m_phase = 2;
          m_age++;
        end
        default: begin
          m_valid[m_miss[2:0]] = 1'b1;
          m_tag[m_miss[2:0]]   = m_miss[5:3];
          m_data[m_miss[2:0]]  = mem_block(m_miss);
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (started) begin
      logic        h;
      logic [31:0] e_instr;
      h       = model_hit();
      e_instr = h ? m_data[cpu_address[6:4]][32*cpu_address[3:2] +: 32] : 32'h0;
      check("instruction", cpu_instruction, e_instr);
      check("cpu_busywait", 32'(cpu_busywait), 32'((m_phase != 0) || (cpu_read && !h)));
      check("mem_read", 32'(mem_read), 32'(m_phase == 1));
      check("mem_address", 32'(mem_address), (m_phase == 1) ? 32'(m_miss) : 32'h0);
      check("miss_count", 32'(miss_count), 32'(m_cnt));
    end
  end

  task automatic fetch(input logic [9:0] a, output int stalls);
    @(posedge clock);
    #1;
    cpu_read    = 1'b1;
    cpu_address = a;
    stalls      = 0;
    forever begin
      @(negedge clock);
      if (!cpu_busywait) break;
      stalls++;
      if (stalls > 40) begin
        n_vec++;
        n_mis++;
        $display("FAIL fetch_timeout addr %h: stalled %0d cycles, limit 40", a, stalls);
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset    = 1'b1;
    cpu_read = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int s;
    logic [127:0] b8;
    reset = 1'b1; cpu_read = 1'b0; cpu_address = '0;
    mem_busywait = 1'b0; mem_readdata = '0;
    @(posedge clock);
    #1;
    started = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset_busywait", 32'(cpu_busywait), 32'd0);
    check("reset_mem_read", 32'(mem_read), 32'd0);
    check("reset_miss_count", 32'(miss_count), 32'd0);

    fetch(10'h000, s);
    check("cold_miss_stalled", 32'(s >= 4), 32'd1);
    check("cold_instr", cpu_instruction, 32'h0001000F);
    check("cold_count", 32'(miss_count), 32'd1);

    fetch(10'h004, s); check("hit4_stalls", 32'(s), 32'd0); check("hit4_instr", cpu_instruction, 32'h0002000C);
    fetch(10'h008, s); check("hit8_stalls", 32'(s), 32'd0); check("hit8_instr", cpu_instruction, 32'h00030001);
    fetch(10'h00C, s); check("hitC_stalls", 32'(s), 32'd0); check("hitC_instr", cpu_instruction, 32'h03010103);
    check("hits_count", 32'(miss_count), 32'd1);

    fetch(10'h010, s);
    check("blk1_stalled", 32'(s >= 4), 32'd1);
    check("blk1_instr", cpu_instruction, 32'h07010102);
    check("blk1_count", 32'(miss_count), 32'd2);

    fetch(10'h080, s);
    b8 = mem_block(6'd8);
    check("conflict_stalled", 32'(s >= 4), 32'd1);
    check("conflict_instr", cpu_instruction, b8[31:0]);
    fetch(10'h000, s);
    check("refill_stalled", 32'(s >= 4), 32'd1);
    check("refill_instr", cpu_instruction, 32'h0001000F);
    check("conflict_count", 32'(miss_count), 32'd4);

    // Reset while the block read is outstanding.
    @(posedge clock);
    #1;
    cpu_address = 10'h020;
    s = 0;
    do begin
      @(negedge clock);
      s++;
    end while (!mem_read && s < 10);
    check("midmiss_mem_read_seen", 32'(mem_read), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0; cpu_read = 1'b0;
    @(negedge clock);
    check("midmiss_mem_read_drop", 32'(mem_read), 32'd0);
    check("midmiss_count_clear", 32'(miss_count), 32'd0);
    repeat (8) @(posedge clock);
    fetch(10'h000, s);
    check("after_reset_miss", 32'(s >= 4), 32'd1);
    check("after_reset_count", 32'(miss_count), 32'd1);
    fetch(10'h020, s);
    check("aborted_blk_not_filled", 32'(s >= 4), 32'd1);

    // Random fetch stream with occasional resets and PC changes mid-miss.
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      #1;
      reset       = ($urandom_range(0, 99) == 0);
      cpu_read    = ($urandom_range(0, 3) != 0);
      cpu_address = 10'($urandom_range(0, 383));
    end

    do_reset();
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      fetch((i % 2) ? 10'h080 : 10'h000, s);
      if (i == (1 << CW) - 2) check("count_at_max", 32'(miss_count), 32'((1 << CW) - 1));
    end
    check("count_saturated", 32'(miss_count), 32'((1 << CW) - 1));

    @(posedge clock);
    #1;
    cpu_read = 1'b0;
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

endmodule
